// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition UART packer.
// State encoding, default sync byte and legal BRAM read latencies.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_WAIT,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/acq_byte_out.sv
// Output holding register for the UART byte stream.
// Holds data and valid stable until the byte is accepted.
module acq_byte_out (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);

  logic [7:0] r_data;
  logic       r_valid;

  // load a new byte, or retire the held one on handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/acq_uart_packer.sv
// Reads a frame of 16-bit words from BRAM and streams it as bytes.
// Optional trailing XOR checksum byte: define PACKER_CHECKSUM_EN.
module acq_uart_packer
  import acq_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_words,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ce,
  input  logic [15:0]           rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  if (!lat_legal(RD_LATENCY)) begin : g_bad_rd_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_WORD =
    (ADDR_WIDTH+1)'(1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_ce;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_left;
  logic [1:0]            r_lat;
  logic [7:0]            r_lo;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_lat_hit;
  logic [ADDR_WIDTH:0]   w_nw_clamp;
  logic                  w_load;
  logic [7:0]            w_ldata;
  logic [7:0]            w_tx_data;
  logic                  w_tx_valid;

  assign w_xfer    = w_tx_valid & tx_ready;
  assign w_last    = (r_left == ONE_WORD);
  assign w_lat_hit = (r_lat == LAT_LAST);

  // frames longer than the address space are cut to its size
  always_comb begin
    w_nw_clamp = n_words;
    if (n_words > MAX_WORDS) begin
      w_nw_clamp = MAX_WORDS;
    end
  end

  // pick the byte the output register loads this cycle
  always_comb begin
    w_load  = 1'b0;
    w_ldata = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        if (start && (n_words != '0)) begin
          w_load  = 1'b1;
          w_ldata = SYNC_BYTE;
        end
      end
      ST_WAIT: begin
        if (w_lat_hit) begin
          w_load  = 1'b1;
          w_ldata = rd_data[15:8];
        end
      end
      ST_HI: begin
        if (w_xfer) begin
          w_load  = 1'b1;
          w_ldata = r_lo;
        end
      end
`ifdef PACKER_CHECKSUM_EN
      ST_LO: begin
        if (w_xfer && w_last) begin
          w_load  = 1'b1;
          w_ldata = r_csum;
        end
      end
`endif
      default: begin
        w_load  = 1'b0;
        w_ldata = 8'h00;
      end
    endcase
  end

  // frame sequencer with registered BRAM and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_rd_ce   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_left    <= '0;
      r_lat     <= '0;
      r_lo      <= 8'h00;
`ifdef PACKER_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      r_rd_ce <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_left <= w_nw_clamp;
`ifdef PACKER_CHECKSUM_EN
            r_csum <= 8'h00;
`endif
            if (n_words != '0) begin
              r_state <= ST_SYNC;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_SYNC: begin
          if (w_xfer) begin
            r_rd_addr <= '0;
            r_rd_ce   <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_lat   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_lat_hit) begin
            r_lo    <= rd_data[7:0];
`ifdef PACKER_CHECKSUM_EN
            r_csum  <= r_csum ^ rd_data[15:8] ^ rd_data[7:0];
`endif
            r_state <= ST_HI;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_left <= r_left - ONE_WORD;
            if (w_last) begin
`ifdef PACKER_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_DONE;
`endif
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
              r_rd_ce   <= 1'b1;
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  acq_byte_out u_byte_out (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ldata),
    .i_ready (tx_ready),
    .o_data  (w_tx_data),
    .o_valid (w_tx_valid)
  );

  assign rd_addr  = r_rd_addr;
  assign rd_ce    = r_rd_ce;
  assign tx_data  = w_tx_data;
  assign tx_valid = w_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_acq_uart_packer.sv
// Randomized bench for acq_uart_packer against a frame-level model.
// Define PACKER_CHECKSUM_EN to match a checksum-enabled build.
module tb_acq_uart_packer;

  localparam int         AW  = 10;
  localparam int         LAT = 1;
  localparam logic [7:0] SB  = 8'hA5;
`ifdef PACKER_CHECKSUM_EN
  localparam int         CS_EXTRA = 1;
`else
  localparam int         CS_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   n_words = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_ce;
  logic [15:0]   rd_data = 16'h0000;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  acq_uart_packer #(
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT),
    .SYNC_BYTE  (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_words  (n_words),
    .rd_addr  (rd_addr),
    .rd_ce    (rd_ce),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  logic [15:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (rd_ce) rd_data <= mem[rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  logic [7:0] got[$];
  int         addrs[$];
  int         viol = 0;
  int         dcnt = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;
  int         rdy_mode = 0;
  int         ph = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (pv && !pr && (!tx_valid || tx_data !== pd)) viol++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      if (rd_ce) addrs.push_back(int'(rd_addr));
      if (done) dcnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 3;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (ph == 0);
        2: tx_ready = 1'($urandom);
        default: ;
      endcase
    end
  end

  task automatic run_frame(input int n, input int mode, input bit poke);
    int         nw;
    int         cyc;
    int         mis;
    int         amis;
    logic [7:0] exp_q[$];
    logic [7:0] cs;
    nw = (n > (1 << AW)) ? (1 << AW) : n;
    exp_q = {};
    cs = 8'h00;
    if (nw != 0) begin
      exp_q.push_back(SB);
      for (int i = 0; i < nw; i++) begin
        exp_q.push_back(mem[i][15:8]);
        exp_q.push_back(mem[i][7:0]);
        cs = cs ^ mem[i][15:8] ^ mem[i][7:0];
      end
      if (CS_EXTRA != 0) exp_q.push_back(cs);
    end
    rdy_mode = mode;
    @(posedge clk);
    #2;
    got = {};
    addrs = {};
    viol = 0;
    dcnt = 0;
    start = 1'b1;
    n_words = (AW+1)'(n);
    @(posedge clk);
    #2;
    start = 1'b0;
    n_words = (AW+1)'($urandom);
    @(negedge clk);
    cyc = 1;
    chk("busy_on", busy, 1);
    chk("first_valid", tx_valid, (nw != 0) ? 1 : 0);
    while (!done && cyc < 40000) begin
      if (poke && cyc == 6) start = 1'b1;
      if (poke && cyc == 7) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    if (nw == 0) chk("zero_cycles", cyc, 2);
    else if (mode == 0)
      chk("cycles", cyc, (3 + LAT) * nw + 3 + CS_EXTRA);
    repeat (3) @(negedge clk);
    chk("done_cnt", dcnt, 1);
    chk("idle_valid", tx_valid, 0);
    chk("busy_off", busy, 0);
    chk("nbytes", got.size(), exp_q.size());
    mis = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        if (mis == 0)
          $display("first byte diff at %0d: %0h vs %0h",
                   i, got[i], exp_q[i]);
        mis++;
      end
    end
    chk("byte_mis", mis, 0);
    chk("naddr", addrs.size(), nw);
    amis = 0;
    for (int i = 0; i < addrs.size(); i++) begin
      if (addrs[i] != i) amis++;
    end
    chk("addr_mis", amis, 0);
    chk("hold", viol, 0);
  endtask

  initial begin
    int n;
    int guard;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ce", rd_ce, 0);
    chk("rst_addr", rd_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_valid", tx_valid, 0);

    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0F0F;
    run_frame(3, 0, 1'b0);
    run_frame(3, 1, 1'b0);
    run_frame(0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      n = int'($urandom_range(2, 20));
      run_frame(n, int'($urandom_range(0, 2)), k == 2);
    end

    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    run_frame(2047, 0, 1'b0);
    if (addrs.size() > 0)
      chk("last_addr", addrs[addrs.size()-1], 32'h3FF);
    else
      chk("last_addr_seen", 0, 1);

    rdy_mode = 3;
    tx_ready = 1'b1;
    got = {};
    @(posedge clk);
    #2;
    start = 1'b1;
    n_words = (AW+1)'(3);
    @(posedge clk);
    #2;
    start = 1'b0;
    guard = 0;
    while (got.size() < 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #2;
    tx_ready = 1'b0;
    guard = 0;
    while (!(tx_valid && tx_data == mem[0][15:8]) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("hi_reached", tx_data, mem[0][15:8]);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", rd_addr, 0);
    rst = 1'b1;
    dcnt = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_nodone", dcnt, 0);
    run_frame(3, 0, 1'b0);

`ifdef PACKER_CHECKSUM_EN
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    run_frame(2, 0, 1'b0);
    if (got.size() > 0)
      chk("csum_byte", got[got.size()-1], 8'h40);
    else
      chk("csum_seen", 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
